// File: rtl/seq_lock_fsm.sv
// Switch-sequence lock: matches one-hot switch entries against a packed code, with failure
// counting, timed lockout, timed open indication and idle-entry abandonment.
module seq_lock_fsm #(
  parameter int unsigned NUM_SW      = 5,
  parameter int unsigned SEQ_LEN     = 4,
  parameter logic [$clog2(NUM_SW)*SEQ_LEN-1:0] CODE = 12'h84A,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned OPEN_CYCLES = 4,
  parameter int unsigned LOCK_CYCLES = 8,
  parameter int unsigned TIMEOUT     = 6
) (
  input  logic                         KEY0,
  input  logic                         KEY1,
  input  logic [NUM_SW-1:0]            SW,
  output logic [2:0]                   state,
  output logic [1:0]                   Z,
  output logic [$clog2(SEQ_LEN+1)-1:0] progress,
  output logic [$clog2(MAX_FAIL+1)-1:0] fails
);

  localparam int unsigned IDX_W   = $clog2(NUM_SW);
  localparam int unsigned PW      = $clog2(SEQ_LEN + 1);
  localparam int unsigned FW      = $clog2(MAX_FAIL + 1);
  localparam int unsigned TMR_MX1 = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int unsigned TMR_MAX = (TMR_MX1 > TIMEOUT) ? TMR_MX1 : TIMEOUT;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [PW-1:0]    LAST_IDX  = PW'(SEQ_LEN - 1);
  localparam logic [FW-1:0]    LAST_FAIL = FW'(MAX_FAIL - 1);
  localparam logic [TMR_W-1:0] T_ENTRY   = TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] T_OPEN    = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] T_LOCK    = TMR_W'(LOCK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_ENTRY   = 3'b001,
    S_OPEN    = 3'b010,
    S_FAIL    = 3'b011,
    S_LOCKOUT = 3'b100
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        z_q, z_d;
  logic [PW-1:0]     progress_q, progress_d;
  logic [FW-1:0]     fails_q, fails_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic              sw_blank_c;
  logic              sw_onehot_c;
  logic [IDX_W-1:0]  sw_digit_c;
  logic [IDX_W-1:0]  exp_digit_c;
  logic              correct_c;

  // Classify the sampled switch vector and look up the digit expected next.
  always_comb begin
    sw_blank_c  = (SW == '0);
    sw_onehot_c = !sw_blank_c && ((SW & (SW - NUM_SW'(1))) == '0);
    sw_digit_c  = '0;
    for (int unsigned i = 0; i < NUM_SW; i++) begin
      if (SW[i]) sw_digit_c = IDX_W'(i);
    end
    exp_digit_c = '0;
    for (int unsigned i = 0; i < SEQ_LEN; i++) begin
      if (progress_q == PW'(i)) exp_digit_c = CODE[IDX_W*i +: IDX_W];
    end
    correct_c = sw_onehot_c && (sw_digit_c == exp_digit_c);
  end

  // Next-state and registered-output logic.
  always_comb begin
    logic go_open;
    logic fail_ev;
    state_d    = state_q;
    progress_d = progress_q;
    fails_d    = fails_q;
    timer_d    = timer_q;
    z_d        = 2'b00;
    go_open    = 1'b0;
    fail_ev    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (correct_c) begin
          if (SEQ_LEN == 1) begin
            go_open = 1'b1;
          end else begin
            state_d    = S_ENTRY;
            progress_d = PW'(1);
            timer_d    = T_ENTRY;
          end
        end else if (!sw_blank_c) begin
          fail_ev = 1'b1;
        end
      end
      S_ENTRY: begin
        if (correct_c) begin
          if (progress_q == LAST_IDX) begin
            go_open = 1'b1;
          end else begin
            progress_d = progress_q + PW'(1);
            timer_d    = T_ENTRY;
          end
        end else if (sw_blank_c) begin
          if (timer_q == '0) begin
            state_d    = S_IDLE;
            progress_d = '0;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end else begin
          fail_ev = 1'b1;
        end
      end
      S_OPEN: begin
        if (timer_q == '0) begin
          state_d    = S_IDLE;
          progress_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      S_FAIL: begin
        state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
          fails_d = '0;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        progress_d = '0;
        timer_d    = '0;
      end
    endcase

    if (go_open) begin
      state_d    = S_OPEN;
      progress_d = PW'(SEQ_LEN);
      fails_d    = '0;
      timer_d    = T_OPEN;
    end

    // A wrong digit ends the attempt; it never seeds a new one.
    if (fail_ev) begin
      progress_d = '0;
      if (fails_q == LAST_FAIL) begin
        state_d = S_LOCKOUT;
        fails_d = FW'(MAX_FAIL);
        timer_d = T_LOCK;
      end else begin
        state_d = S_FAIL;
        fails_d = fails_q + FW'(1);
      end
    end

    case (state_d)
      S_OPEN:    z_d = 2'b01;
      S_FAIL:    z_d = 2'b10;
      S_LOCKOUT: z_d = 2'b11;
      default:   z_d = 2'b00;
    endcase
  end

  always_ff @(posedge KEY0 or negedge KEY1) begin
    if (!KEY1) begin
      state_q    <= S_IDLE;
      z_q        <= 2'b00;
      progress_q <= '0;
      fails_q    <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      z_q        <= z_d;
      progress_q <= progress_d;
      fails_q    <= fails_d;
      timer_q    <= timer_d;
    end
  end

  assign state    = state_q;
  assign Z        = z_q;
  assign progress = progress_q;
  assign fails    = fails_q;

endmodule

// File: tb/tb_seq_lock_fsm.sv
// Bench for seq_lock_fsm: directed scenarios plus randomized switch traffic against a
// behavioural lock model, compared on every falling clock edge.
module tb_seq_lock_fsm;

  localparam int NUM_SW      = 5;
  localparam int SEQ_LEN     = 4;
  localparam int MAX_FAIL    = 3;
  localparam int OPEN_CYCLES = 4;
  localparam int LOCK_CYCLES = 8;
  localparam int TIMEOUT     = 6;
  localparam logic [11:0] CODE_V = 12'h84A;

  logic              KEY0 = 1'b0;
  logic              KEY1 = 1'b0;
  logic [NUM_SW-1:0] SW   = '0;
  logic [2:0]        state;
  logic [1:0]        Z;
  logic [2:0]        progress;
  logic [1:0]        fails;

  seq_lock_fsm dut (
    .KEY0     (KEY0),
    .KEY1     (KEY1),
    .SW       (SW),
    .state    (state),
    .Z        (Z),
    .progress (progress),
    .fails    (fails)
  );

  always #5 KEY0 = ~KEY0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase uses the externally visible state codes; counters count
  // cycles remaining / blanks seen rather than mirroring any internal timer.
  int code[SEQ_LEN];
  int m_state = 0;
  int m_prog  = 0;
  int m_fails = 0;
  int m_left  = 0;
  int m_blank = 0;

  initial begin
    for (int i = 0; i < SEQ_LEN; i++) code[i] = int'((CODE_V >> (3 * i)) & 12'h7);
  end

  function automatic void model_reset();
    m_state = 0; m_prog = 0; m_fails = 0; m_left = 0; m_blank = 0;
  endfunction

  function automatic void model_step(input logic [NUM_SW-1:0] s);
    int ones;
    int dig;
    ones = $countones(s);
    dig  = -1;
    for (int i = 0; i < NUM_SW; i++) if (s[i]) dig = i;
    case (m_state)
      0, 1: begin
        if (ones == 0) begin
          if (m_state == 1) begin
            m_blank++;
            if (m_blank == TIMEOUT) begin m_state = 0; m_prog = 0; end
          end
        end else if (ones == 1 && dig == code[m_prog]) begin
          m_prog++;
          m_blank = 0;
          if (m_prog == SEQ_LEN) begin
            m_state = 2; m_fails = 0; m_left = OPEN_CYCLES;
          end else begin
            m_state = 1;
          end
        end else begin
          m_prog = 0;
          m_fails++;
          if (m_fails == MAX_FAIL) begin m_state = 4; m_left = LOCK_CYCLES; end
          else m_state = 3;
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin m_state = 0; m_prog = 0; end
      end
      3: m_state = 0;
      4: begin
        m_left--;
        if (m_left == 0) begin m_state = 0; m_fails = 0; end
      end
      default: m_state = 0;
    endcase
  endfunction

  function automatic int model_z();
    case (m_state)
      2:       return 1;
      3:       return 2;
      4:       return 3;
      default: return 0;
    endcase
  endfunction

  always @(posedge KEY0 or negedge KEY1) begin
    if (!KEY1) model_reset();
    else       model_step(SW);
  end

  always @(negedge KEY0) begin
    chk("model_state",    int'(state),    m_state);
    chk("model_z",        int'(Z),        model_z());
    chk("model_progress", int'(progress), m_prog);
    chk("model_fails",    int'(fails),    m_fails);
  end

  // Drive SW away from the edge, then settle 2ns past the next rising edge.
  task automatic step(input logic [NUM_SW-1:0] s);
    SW = s;
    @(posedge KEY0);
    #2;
  endtask

  task automatic do_reset();
    SW   = '0;
    KEY1 = 1'b0;
    #4;
    KEY1 = 1'b1;
    @(posedge KEY0);
    #2;
  endtask

  task automatic pin(input string name, input int st, input int z, input int pr, input int fl);
    chk({name, "_state"}, int'(state), st);
    if (z  >= 0) chk({name, "_z"},        int'(Z),        z);
    if (pr >= 0) chk({name, "_progress"}, int'(progress), pr);
    if (fl >= 0) chk({name, "_fails"},    int'(fails),    fl);
  endtask

  initial begin
    logic [NUM_SW-1:0] s;
    int r;

    #12;
    pin("reset", 0, 0, 0, 0);
    KEY1 = 1'b1;
    @(posedge KEY0);
    #2;

    // Correct code 2,1,1,4
    step(5'b00100); pin("ok1", 1, 0, 1, 0);
    step(5'b00010); pin("ok2", 1, 0, 2, 0);
    step(5'b00010); pin("ok3", 1, 0, 3, 0);
    step(5'b10000); pin("open1", 2, 1, 4, 0);
    for (int i = 0; i < 3; i++) begin step('0); pin("open_hold", 2, 1, 4, 0); end
    step('0); pin("open_done", 0, 0, 0, 0);

    // Wrong second digit
    step(5'b00100);
    step(5'b01000); pin("wrong", 3, 2, 0, 1);
    step('0);       pin("wrong_after", 0, 0, 0, 1);

    // Lockout after three wrong entries; code ignored during lockout
    do_reset();
    step(5'b01000); pin("lk_f1", 3, 2, 0, 1);
    step('0);
    step(5'b01000); pin("lk_f2", 3, 2, 0, 2);
    step('0);
    step(5'b01000); pin("lk_in", 4, 3, 0, 3);
    step(5'b00100); pin("lk_c1", 4, 3, 0, 3);
    step(5'b00010); pin("lk_c2", 4, 3, 0, 3);
    step(5'b00010); pin("lk_c3", 4, 3, 0, 3);
    step(5'b10000); pin("lk_c4", 4, 3, 0, 3);
    for (int i = 0; i < 3; i++) begin step('0); pin("lk_hold", 4, 3, 0, 3); end
    step('0); pin("lk_done", 0, 0, 0, 0);

    // Invalid entry and long blank idle
    step(5'b00011); pin("invalid", 3, 2, 0, 1);
    for (int i = 0; i < 20; i++) step('0);
    pin("idle_hold", 0, 0, 0, 1);

    // Entry timeout
    step(5'b00100);
    for (int i = 0; i < 5; i++) step('0);
    pin("to_5blank", 1, 0, 1, 1);
    step(5'b00010); pin("to_next", 1, 0, 2, 1);
    for (int i = 0; i < 5; i++) step('0);
    pin("to_5blank_b", 1, 0, 2, 1);
    step('0); pin("to_abandon", 0, 0, 0, 1);

    // Async reset during lockout
    step(5'b01000);
    step('0);
    step(5'b01000); pin("ar_lock", 4, 3, 0, 3);
    step('0);
    step('0);
    #1 KEY1 = 1'b0;
    #1 pin("ar_now", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge KEY0); #1;
      pin("ar_held", 0, 0, 0, 0);
    end
    @(posedge KEY0); #2;
    KEY1 = 1'b1;
    step('0); pin("ar_release", 0, 0, 0, 0);

    // Randomized traffic biased towards the code so OPEN and lockout both occur
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35)                            s = '0;
      else if (r < 75 && m_prog < SEQ_LEN)   s = NUM_SW'(1) << code[m_prog];
      else if (r < 88)                       s = NUM_SW'(1) << $urandom_range(0, NUM_SW - 1);
      else                                   s = NUM_SW'($urandom);
      step(s);
      if ($urandom_range(0, 299) == 0) begin
        #1 KEY1 = 1'b0;
        #3 KEY1 = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
